// File: rtl/lock_pkg.sv
// Shared definitions for the digital-lock keypad front-end.
//   - Keypad geometry (4 rows x 3 columns, 12 keys) and the indices of the
//     three command keys on the lock's key[11:0] bus.
//   - Scanner state encoding.
//   - Small helpers that map matrix positions to key indices and row drives.
package lock_pkg;

  localparam int NUM_KEYS = 12;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  // Command keys live on row 3.
  localparam int KEY_STAR = 9;   // undo
  localparam int KEY_ZERO = 10;  // enter
  localparam int KEY_HASH = 11;  // cancel

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } scan_state_e;

  // Key index = row*3 + col (0..11).
  function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} * 4'd3) + {2'b00, col};
  endfunction

  // Lowest-numbered active-low column; only meaningful when some bit is low.
  function automatic logic [1:0] lowest_low_col(input logic [NUM_COLS-1:0] cols);
    if (!cols[0])      return 2'd0;
    else if (!cols[1]) return 2'd1;
    else               return 2'd2;
  endfunction

  // One-cold row drive for the selected row.
  function automatic logic [NUM_ROWS-1:0] row_drive(input logic [1:0] row);
    return ~(NUM_ROWS'(1) << row);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad / lock-facing signal bundle of the scanner.
//   col_in    : keypad columns, active-low, asynchronous to clk
//   row_out   : keypad rows, one-cold active-low drive
//   key       : one-hot level of the accepted key (0 when idle)
//   key_code  : index of the last accepted key (holds after release)
//   key_pulse : one-cycle strobe when a press is accepted
//   key_held  : high while an accepted key is held
// master = the scanner, slave = the keypad/lock side.
interface keypad_scanner_if;

  logic [lock_pkg::NUM_COLS-1:0] col_in;
  logic [lock_pkg::NUM_ROWS-1:0] row_out;
  logic [lock_pkg::NUM_KEYS-1:0] key;
  logic [3:0]                    key_code;
  logic                          key_pulse;
  logic                          key_held;

  modport master (
    input  col_in,
    output row_out, key, key_code, key_pulse, key_held
  );

  modport slave (
    output col_in,
    input  row_out, key, key_code, key_pulse, key_held
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
//   clk  : destination clock
//   rst  : asynchronous active-low reset; both stages reset to all-ones,
//          matching the idle (pulled-up) level of the keypad columns
//   d_i  : asynchronous input
//   q_o  : synchronised output (two clk cycles of latency)
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of the others; blocking here would
  // collapse the two stages into one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner and debouncer for the digital lock.
//   clk : system clock
//   rst : asynchronous active-low reset
//   kp  : keypad_scanner_if.master (col_in in; row_out, key, key_code,
//         key_pulse, key_held out)
// Parameters:
//   SCAN_DIV        : clk cycles each row is driven before sampling (>= 4)
//   DEBOUNCE_CYCLES : stable cycles needed to accept a press/release (>= 2)
//
// Rows are driven one at a time; when a column reads low at the end of a
// row slot, that (row, column) is latched and debounced. Once accepted the
// key is presented as a one-hot level until its release has been debounced.
// Only the latched column is watched outside SCAN, so other keys are
// ignored until a full release and rescan.
module keypad_scanner
  import lock_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic               clk,
  input  logic               rst,
  keypad_scanner_if.master   kp
);

  localparam int DIV_W = (SCAN_DIV > 1)        ? $clog2(SCAN_DIV)        : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  // Synchronised columns; every decision below looks only at cs.
  logic [NUM_COLS-1:0] cs;

  sync2 #(.WIDTH(NUM_COLS)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d_i (kp.col_in),
    .q_o (cs)
  );

  scan_state_e         state_q, state_d;
  logic [1:0]          row_q,   row_d;
  logic [1:0]          col_q,   col_d;
  logic [DIV_W-1:0]    div_q,   div_d;
  logic [DEB_W-1:0]    deb_q,   deb_d;
  logic [NUM_ROWS-1:0] row_out_q;
  logic [NUM_KEYS-1:0] key_q,   key_d;
  logic [3:0]          code_q,  code_d;
  logic                pulse_q, pulse_d;
  logic                held_q,  held_d;

  logic                col_up;     // latched column currently released
  logic [3:0]          cur_idx;

  assign col_up  = cs[col_q];
  assign cur_idx = key_index(row_q, col_q);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    div_d   = div_q;
    deb_d   = deb_q;
    key_d   = key_q;
    code_d  = code_q;
    pulse_d = 1'b0;
    held_d  = held_q;

    unique case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (cs != '1) begin
            // Stay on this row; debounce the lowest low column.
            col_d   = lowest_low_col(cs);
            deb_d   = '0;
            state_d = DEB_PRESS;
          end else begin
            row_d = row_q + 2'd1;  // 3 wraps to 0
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      DEB_PRESS: begin
        if (!col_up) begin
          if (deb_q == DEB_LAST) begin
            key_d          = '0;
            key_d[cur_idx] = 1'b1;
            code_d         = cur_idx;
            pulse_d        = 1'b1;
            held_d         = 1'b1;
            state_d        = PRESSED;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end else begin
          // Bounce: resume scanning the same row from a fresh slot.
          div_d   = '0;
          state_d = SCAN;
        end
      end

      PRESSED: begin
        if (col_up) begin
          deb_d   = '0;
          state_d = DEB_RELEASE;
        end
      end

      DEB_RELEASE: begin
        if (col_up) begin
          if (deb_q == DEB_LAST) begin
            key_d   = '0;
            held_d  = 1'b0;
            row_d   = 2'd0;
            div_d   = '0;
            state_d = SCAN;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end else begin
          // Release glitch: key level was never dropped, so no new pulse.
          state_d = PRESSED;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  // NOTE: every flop, including the row drive, has an explicit async reset
  // value so the keypad sees a defined row and the lock sees no key the
  // moment rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SCAN;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      div_q     <= '0;
      deb_q     <= '0;
      row_out_q <= 4'b1110;
      key_q     <= '0;
      code_q    <= 4'd0;
      pulse_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      div_q     <= div_d;
      deb_q     <= deb_d;
      // Registered decode keeps the row drive glitch-free.
      row_out_q <= row_drive(row_d);
      key_q     <= key_d;
      code_q    <= code_d;
      pulse_q   <= pulse_d;
      held_q    <= held_d;
    end
  end

  assign kp.row_out   = row_out_q;
  assign kp.key       = key_q;
  assign kp.key_code  = code_q;
  assign kp.key_pulse = pulse_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CYCLES=8).
// A behavioural keypad model pulls a column low whenever a pressed key's row
// is driven. Stimulus pushes the key index it expects to be accepted into a
// scoreboard queue; an independent monitor pops and compares on key_pulse.
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DEB = 8;
  localparam int PRESS_BUDGET = 2 * 4 * SD + DEB + 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  // Physical keypad: key k sits on row k/3, column k%3.
  logic [11:0] pressed = '0;
  always_comb begin
    kp.col_in = 3'b111;
    for (int k = 0; k < 12; k++)
      if (pressed[k] && kp.row_out[k / 3] == 1'b0) kp.col_in[k % 3] = 1'b0;
  end

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  bit mon_en = 1'b0;
  bit prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst && mon_en) begin
      check("key_onehot", {31'd0, $onehot0(kp.key)}, 32'd1);
      if (kp.key_pulse) begin
        check("pulse_not_consecutive", {31'd0, prev_pulse}, 32'd0);
        check("pulse_implies_held", {31'd0, kp.key_held}, 32'd1);
        check("pulse_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          int e;
          e = exp_q.pop_front();
          check("pulse_key", {20'd0, kp.key}, 32'd1 << e);
          check("pulse_code", {28'd0, kp.key_code}, e);
        end
      end
      prev_pulse = kp.key_pulse;
    end
  end

  task automatic wait_held(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < PRESS_BUDGET; i++) begin
      @(negedge clk);
      if (kp.key_held) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic press(input int code);
    exp_q.push_back(code);
    pressed[code] = 1'b1;
    wait_held("press_accept");
  endtask

  // Release and check: key clears 3+DEB edges after the column rises
  // (2 sync, 1 to enter release debounce, DEB counted cycles).
  task automatic release_key(input int code);
    int n = 0;
    pressed[code] = 1'b0;
    for (int i = 0; i < 4 * DEB; i++) begin
      @(negedge clk);
      n++;
      if (kp.key == 12'd0) break;
    end
    check("release_latency", n, 3 + DEB);
    check("release_held", {31'd0, kp.key_held}, 32'd0);
    check("release_row", {28'd0, kp.row_out}, 32'hE);
    check("release_code_holds", {28'd0, kp.key_code}, code);
  endtask

  task automatic hold_check(input int code, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("hold_key", {20'd0, kp.key}, 32'd1 << code);
    end
  endtask

  // Release glitch shorter than the release debounce: key must stay.
  task automatic glitch(input int code, input int len);
    pressed[code] = 1'b0;
    hold_check(code, len);
    pressed[code] = 1'b1;
    hold_check(code, 2 * DEB);
  endtask

  // Bounce before a steady press: low b cycles, high 2 cycles.
  task automatic bounce(input int code, input int b);
    pressed[code] = 1'b1;
    repeat (b) @(negedge clk);
    pressed[code] = 1'b0;
    repeat (2) @(negedge clk);
    check("bounce_no_key", {20'd0, kp.key}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_row_out", {28'd0, kp.row_out}, 32'hE);
    check("rst_key", {20'd0, kp.key}, 32'd0);
    check("rst_code", {28'd0, kp.key_code}, 32'd0);
    check("rst_pulse", {31'd0, kp.key_pulse}, 32'd0);
    check("rst_held", {31'd0, kp.key_held}, 32'd0);
    rst = 1'b1;
    mon_en = 1'b1;

    // Idle scan: each row driven for SD cycles, in order, wrapping.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] exp_row;
      int r;
      @(negedge clk);
      r = ((i + 1) / SD) % 4;
      exp_row = ~(4'b0001 << r);
      check("idle_row_out", {28'd0, kp.row_out}, {28'd0, exp_row});
      check("idle_key", {20'd0, kp.key}, 32'd0);
    end

    // Clean "5".
    press(4);
    hold_check(4, 50);
    release_key(4);

    // Bouncing "#".
    bounce(11, 3);
    press(11);
    hold_check(11, 10);
    release_key(11);

    // "*" with a release glitch.
    press(9);
    hold_check(9, 10);
    glitch(9, 3);
    release_key(9);

    // "1" and "3" together: column 0 wins, "3" taken only after rescan.
    exp_q.push_back(0);
    pressed[0] = 1'b1;
    pressed[2] = 1'b1;
    wait_held("press_accept_two");
    hold_check(0, 20);
    release_key(0);
    exp_q.push_back(2);
    wait_held("press_accept_rescan");
    hold_check(2, 5);
    release_key(2);

    // Reset while "0" is held, then re-acceptance.
    press(10);
    hold_check(10, 6);
    rst = 1'b0;
    #1;
    check("midrst_key", {20'd0, kp.key}, 32'd0);
    check("midrst_held", {31'd0, kp.key_held}, 32'd0);
    check("midrst_row_out", {28'd0, kp.row_out}, 32'hE);
    check("midrst_pulse", {31'd0, kp.key_pulse}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("postrst_no_pulse", {31'd0, kp.key_pulse}, 32'd0);
    exp_q.push_back(10);
    wait_held("press_accept_after_rst");
    check("postrst_key", {20'd0, kp.key}, 32'h400);
    hold_check(10, 4);
    release_key(10);

    // Randomised presses with optional bounce and release glitch.
    for (int it = 0; it < 16; it++) begin
      int code;
      code = $urandom_range(0, 11);
      repeat ($urandom_range(0, 6)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) bounce(code, $urandom_range(1, 5));
      press(code);
      hold_check(code, $urandom_range(3, 20));
      if ($urandom_range(0, 1) == 1) glitch(code, $urandom_range(1, DEB - 1));
      release_key(code);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
